// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// and a debug/loader port, with bounded lock and registered read data.
module dmem_arbiter #(
    parameter int DEPTH    = 101,
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t        state;
    state_t        state_nx;
    logic          last;
    logic [CW-1:0] lock_cnt;
    logic          serving;
    logic          we_sel;
    logic          bad;
    logic          cur_req;
    logic          cur_lock;
    logic          oth_req;
    logic [31:0]   a_sel;
    logic [31:0]   wd_sel;

    assign gnt0    = (state == SERVE0);
    assign gnt1    = (state == SERVE1);
    assign serving = gnt0 | gnt1;

    always_comb begin
        a_sel    = 32'h0;
        wd_sel   = 32'h0;
        we_sel   = 1'b0;
        cur_req  = 1'b0;
        cur_lock = 1'b0;
        oth_req  = 1'b0;
        unique case (1'b1)
            gnt0: begin
                a_sel    = a0;
                wd_sel   = wd0;
                we_sel   = we0;
                cur_req  = req0;
                cur_lock = lock0;
                oth_req  = req1;
            end
            gnt1: begin
                a_sel    = a1;
                wd_sel   = wd1;
                we_sel   = we1;
                cur_req  = req1;
                cur_lock = lock1;
                oth_req  = req0;
            end
            default: ;
        endcase
    end

    assign bad    = (a_sel[1:0] != 2'b00) || (a_sel[31:2] >= 30'(DEPTH));
    assign mem_we = serving & we_sel & ~bad;
    assign mem_a  = a_sel;
    assign mem_wd = wd_sel;

    // Lock holds the grant until the bound is hit, but only while contended.
    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) begin
            if (req0 && req1)
                state_nx = last ? SERVE0 : SERVE1;
            else if (req0)
                state_nx = SERVE0;
            else if (req1)
                state_nx = SERVE1;
        end else begin
            if (cur_lock && cur_req && (lock_cnt < CNT_MAX || !oth_req))
                state_nx = state;
            else if (oth_req)
                state_nx = gnt0 ? SERVE1 : SERVE0;
            else if (cur_req)
                state_nx = state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            state <= state_nx;
            if (gnt0)
                last <= 1'b0;
            else if (gnt1)
                last <= 1'b1;
            if (!serving || state_nx != state)
                lock_cnt <= '0;
            else if (oth_req && lock_cnt != CNT_MAX)
                lock_cnt <= lock_cnt + CW'(1);
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            err0    <= gnt0 & bad;
            err1    <= gnt1 & bad;
            if (serving && !we_sel)
                rdata <= bad ? 32'h0 : mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single accesses plus
// contention, lock-bound and mid-access reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(101), .LOCK_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    logic [31:0] mem [0:127];
    assign mem_rd = (mem_a[31:9] == 23'h0) ? mem[mem_a[8:2]] : 32'h0;
    always @(posedge clk)
        if (mem_we && mem_a[31:9] == 23'h0) mem[mem_a[8:2]] <= mem_wd;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_mwe;
    } vec_t;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] last_rd = 32'h0;
    vec_t        vecs [10];
    vec_t        v;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_txn(vec_t t);
        @(negedge clk);
        if (t.port == 1'b0) begin
            req0 = 1'b1; we0 = t.we; a0 = t.a; wd0 = t.wd;
        end else begin
            req1 = 1'b1; we1 = t.we; a1 = t.a; wd1 = t.wd;
        end
        @(negedge clk);
        check("gnt_own", t.port ? gnt1 : gnt0, 1);
        check("gnt_other", t.port ? gnt0 : gnt1, 0);
        check("mem_we", mem_we, t.exp_mwe);
        check("mem_a", mem_a, t.a);
        check("mem_wd", mem_wd, t.wd);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("rvalid", t.port ? rvalid1 : rvalid0, !t.we);
        check("rvalid_other", t.port ? rvalid0 : rvalid1, 0);
        check("err", t.port ? err1 : err0, t.exp_err);
        check("err_other", t.port ? err0 : err1, 0);
        check("mem_we_off", mem_we, 0);
        if (!t.we) last_rd = t.exp_rd;
        check("rdata", rdata, last_rd);
    endtask

    bit exp_cont [6] = '{0, 1, 0, 1, 0, 1};
    bit exp_lock [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = {4{i[7:0]}};
        mem[5]   = 32'hDEADBEEF;
        mem[100] = 32'hCAFEF00D;

        vecs[0] = '{0, 0, 32'h14,  32'h0,        32'hDEADBEEF, 0, 0};
        vecs[1] = '{1, 1, 32'h20,  32'h12345678, 32'h0,        0, 1};
        vecs[2] = '{1, 0, 32'h20,  32'h0,        32'h12345678, 0, 0};
        vecs[3] = '{0, 1, 32'h196, 32'hAAAA5555, 32'h0,        1, 0};
        vecs[4] = '{0, 0, 32'h194, 32'h0,        32'h0,        1, 0};
        vecs[5] = '{0, 0, 32'h190, 32'h0,        32'hCAFEF00D, 0, 0};
        vecs[6] = '{0, 1, 32'h0,   32'h11111111, 32'h0,        0, 1};
        vecs[7] = '{1, 0, 32'h0,   32'h0,        32'h11111111, 0, 0};
        vecs[8] = '{1, 1, 32'h7,   32'hFFFFFFFF, 32'h0,        1, 0};
        vecs[9] = '{1, 0, 32'h4,   32'h0,        32'h01010101, 0, 0};

        reset_n = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
        #3;
        check("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wd", mem_wd, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);
        check("bad_wr_mem101", mem[101], 32'h65656565);
        check("mis_wr_mem1", mem[1], 32'h01010101);

        // Contention without lock: strict alternation starting at port 0.
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; a0 = 32'h14; a1 = 32'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont_gnt0", gnt0, !exp_cont[i]);
            check("cont_gnt1", gnt1, exp_cont[i]);
            if (i == 5) begin req0 = 0; req1 = 0; end
        end

        // Lock on port 0 bounded to four grants while port 1 waits.
        @(negedge clk);
        lock0 = 1; req0 = 1; req1 = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("lock_gnt0", gnt0, !exp_lock[i]);
            check("lock_gnt1", gnt1, exp_lock[i]);
            if (i == 8) begin lock0 = 0; req0 = 0; req1 = 0; end
        end
        @(negedge clk);

        // Reset asserted in the middle of a port 1 write grant.
        @(negedge clk);
        req1 = 1; we1 = 1; a1 = 32'h40; wd1 = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst_mid_gnt1", gnt1, 1);
        check("rst_mid_we_pre", mem_we, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_gnt", {gnt0, gnt1}, 0);
        check("rst_mid_a", mem_a, 0);
        check("rst_mid_wd", mem_wd, 0);
        req1 = 0; we1 = 0; a1 = 0; wd1 = 0;
        @(negedge clk);
        check("rst_mid_outs", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_mem16", mem[16], 32'h10101010);
        reset_n = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        check("rst_post_rvalid", {rvalid0, rvalid1, err0, err1}, 0);
        v = '{1, 0, 32'h40, 32'h0, 32'h10101010, 0, 0};
        do_txn(v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
